dmem_responder: RTL and testbench

// - Responder side of the data-memory load/store interface. The memory stage
//   (initiator) issues requests; this block is the memory end that serves them.
// - Accepts one request at a time over a valid/ready handshake.
// - Performs a byte/half/word load or store on an internal word array after

---
 rtl/dmem_responder_pkg.sv | 16 +
 rtl/dmem_lane_align.sv | 47 ++++
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: access size and FSM state encodings.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and store-data replication for writes,
// extraction plus sign/zero extension for loads, and the misalignment flag.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata,
    output logic        misalign
);

    // Aligned byte/half accesses land in the low bits once shifted by the lane.
    logic [15:0] rsh;
    assign rsh = 16'(rword >> {lane, 3'b000});

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata     = '0;
        misalign  = 1'b0;
        case (size)
            BYTE: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
                rdata     = {{24{sign & rsh[7]}}, rsh[7:0]};
            end
            HALF: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata     = {{16{sign & rsh[15]}}, rsh[15:0]};
                misalign  = lane[0];
            end
            WORD: begin
                be       = 4'b1111;
                rdata    = rword;
                misalign = (lane != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES stall cycles, then a
// held response. Models multi-cycle memory for pipeline stall testing.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_t       state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] a_addr;
    logic              a_write;
    logic [31:0]       a_wdata;
    logic [1:0]        a_size;
    logic              a_sign;

    logic [31:0]       mem [DEPTH];

    logic [IDX_W-1:0]  widx;
    logic [31:0]       rword;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [31:0]       ld_data;
    logic              misalign;
    logic              oor;
    logic              err;
    logic              do_access;
    logic              do_write;

    assign widx  = a_addr[IDX_W+1:2];
    assign rword = mem[widx];
    assign oor   = 32'(a_addr) >= 32'(DEPTH) * 32'd4;
    assign err   = misalign | (a_size == 2'd3) | oor;

    assign do_access = (state == ACCESS) && (cnt == 4'd0);
    assign do_write  = do_access && a_write && !err;

    // Gated by reset_n so the initiator never sees ready while reset is held.
    assign req_ready = (state == IDLE) && reset_n;

    dmem_lane_align u_align (
        .size      (a_size),
        .lane      (a_addr[1:0]),
        .sign      (a_sign),
        .wdata     (a_wdata),
        .rword     (rword),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata     (ld_data),
        .misalign  (misalign)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_addr    <= '0;
            a_write   <= 1'b0;
            a_wdata   <= '0;
            a_size    <= '0;
            a_sign    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_addr  <= req_addr;
                        a_write <= req_write;
                        a_wdata <= req_wdata;
                        a_size  <= req_size;
                        a_sign  <= req_sign;
                        cnt     <= 4'(WAIT_STATES);
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (err || a_write) ? 32'd0 : ld_data;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array is deliberately left out of reset; async reset forces state out of
    // ACCESS, so no write can happen at an edge while reset is held.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: table of load/store vectors on a zero-wait instance, plus
// hand-written backpressure and mid-access reset sequences on a 3-wait instance.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid0, valid3;
    logic [12:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sign;
    logic        rsp_ready;

    logic        rdy0, vld0, err0, rdy3, vld3, err3;
    logic [31:0] rdata0, rdata3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .ADDR_W(13), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset_n(reset_n), .req_valid(valid0), .req_ready(rdy0),
        .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
        .req_size(req_size), .req_sign(req_sign), .rsp_valid(vld0),
        .rsp_ready(rsp_ready), .rsp_rdata(rdata0), .rsp_err(err0)
    );

    dmem_responder #(.DEPTH(1024), .ADDR_W(12), .WAIT_STATES(3)) u3 (
        .clk(clk), .reset_n(reset_n), .req_valid(valid3), .req_ready(rdy3),
        .req_addr(req_addr[11:0]), .req_write(req_write), .req_wdata(req_wdata),
        .req_size(req_size), .req_sign(req_sign), .rsp_valid(vld3),
        .rsp_ready(rsp_ready), .rsp_rdata(rdata3), .rsp_err(err3)
    );

    typedef struct {
        logic [12:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic cur_rdy(input int sel);
        return (sel == 0) ? rdy0 : rdy3;
    endfunction
    function automatic logic cur_vld(input int sel);
        return (sel == 0) ? vld0 : vld3;
    endfunction
    function automatic logic [31:0] cur_rdata(input int sel);
        return (sel == 0) ? rdata0 : rdata3;
    endfunction
    function automatic logic cur_err(input int sel);
        return (sel == 0) ? err0 : err3;
    endfunction

    // Called just after a negedge; returns just after a negedge with the
    // responder back in IDLE.
    task automatic txn(input string tag, input int sel, input vec_t v, input int stall);
        int lat;
        int exp_lat;
        exp_lat = (sel == 0) ? 2 : 5;
        chk({tag, " req_ready idle"}, 32'(cur_rdy(sel)), 32'd1);
        req_addr  = v.addr;
        req_write = v.write;
        req_wdata = v.wdata;
        req_size  = v.size;
        req_sign  = v.sign;
        rsp_ready = 1'b0;
        if (sel == 0) valid0 = 1'b1; else valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid0    = 1'b0;
        valid3    = 1'b0;
        req_wdata = 32'h5A5A5A5A;
        req_addr  = 13'h0;
        lat = 1;
        while (!cur_vld(sel) && lat < 40) begin
            chk({tag, " req_ready busy"}, 32'(cur_rdy(sel)), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " rdata"}, cur_rdata(sel), v.exp_rdata);
        chk({tag, " err"}, 32'(cur_err(sel)), 32'(v.exp_err));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, " stall valid"}, 32'(cur_vld(sel)), 32'd1);
            chk({tag, " stall rdata"}, cur_rdata(sel), v.exp_rdata);
            chk({tag, " stall ready"}, 32'(cur_rdy(sel)), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " valid drop"}, 32'(cur_vld(sel)), 32'd0);
    endtask

    function automatic vec_t mk(input logic [12:0] a, input logic w, input logic [31:0] wd,
                                input logic [1:0] sz, input logic sg,
                                input logic [31:0] er_d, input logic er);
        vec_t v;
        v.addr = a; v.write = w; v.wdata = wd; v.size = sz; v.sign = sg;
        v.exp_rdata = er_d; v.exp_err = er;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL global timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        reset_n = 1'b0; valid0 = 1'b0; valid3 = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_size = '0; req_sign = 1'b0; rsp_ready = 1'b0;

        // Word store/load, lanes and extension, partial store, errors.
        vecs.push_back(mk(13'h010, 1, 32'hDEADBEEF, WORD, 0, 32'h0,        0));
        vecs.push_back(mk(13'h010, 0, 32'h0,        WORD, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(13'h020, 1, 32'h80FF7F01, WORD, 0, 32'h0,        0));
        vecs.push_back(mk(13'h023, 0, 32'h0,        BYTE, 1, 32'hFFFFFF80, 0));
        vecs.push_back(mk(13'h022, 0, 32'h0,        BYTE, 0, 32'h000000FF, 0));
        vecs.push_back(mk(13'h020, 0, 32'h0,        HALF, 1, 32'h00007F01, 0));
        vecs.push_back(mk(13'h022, 0, 32'h0,        HALF, 1, 32'hFFFF80FF, 0));
        vecs.push_back(mk(13'h021, 1, 32'h000000AA, BYTE, 0, 32'h0,        0));
        vecs.push_back(mk(13'h020, 0, 32'h0,        WORD, 0, 32'h80FFAA01, 0));
        vecs.push_back(mk(13'h030, 1, 32'h12345678, WORD, 0, 32'h0,        0));
        vecs.push_back(mk(13'h000, 1, 32'h0BADF00D, WORD, 0, 32'h0,        0));
        vecs.push_back(mk(13'h031, 1, 32'h0000FFFF, HALF, 0, 32'h0,        1));
        vecs.push_back(mk(13'h032, 0, 32'h0,        WORD, 0, 32'h0,        1));
        vecs.push_back(mk(13'h033, 0, 32'h0,        HALF, 1, 32'h0,        1));
        vecs.push_back(mk(13'h030, 1, 32'hFFFFFFFF, 2'd3, 0, 32'h0,        1));
        vecs.push_back(mk(13'h030, 0, 32'h0,        2'd3, 0, 32'h0,        1));
        vecs.push_back(mk(13'h1000, 1, 32'hFFFFFFFF, WORD, 0, 32'h0,       1));
        vecs.push_back(mk(13'h1000, 0, 32'h0,       WORD, 0, 32'h0,        1));
        vecs.push_back(mk(13'h000, 0, 32'h0,        WORD, 0, 32'h0BADF00D, 0));
        vecs.push_back(mk(13'h030, 0, 32'h0,        WORD, 0, 32'h12345678, 0));
        vecs.push_back(mk(13'h031, 0, 32'h0,        BYTE, 0, 32'h00000056, 0));
        vecs.push_back(mk(13'h032, 0, 32'h0,        HALF, 0, 32'h00001234, 0));
        vecs.push_back(mk(13'h032, 1, 32'h0000BEEF, HALF, 0, 32'h0,        0));
        vecs.push_back(mk(13'h030, 0, 32'h0,        WORD, 1, 32'hBEEF5678, 0));
        vecs.push_back(mk(13'h032, 0, 32'h0,        HALF, 1, 32'hFFFFBEEF, 0));
        vecs.push_back(mk(13'h030, 0, 32'h0,        BYTE, 1, 32'h00000078, 0));

        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(rdy0), 32'd0);
        chk("reset rsp_valid", 32'(vld0), 32'd0);
        chk("reset rsp_rdata", rdata0, 32'd0);
        chk("reset rsp_err",   32'(err0), 32'd0);
        chk("reset req_ready w3", 32'(rdy3), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("release req_ready", 32'(rdy0), 32'd1);

        foreach (vecs[i]) txn($sformatf("vec%0d", i), 0, vecs[i], 0);

        // Backpressure with wait states.
        txn("ws store", 3, mk(13'h040, 1, 32'hCAFEF00D, WORD, 0, 32'h0, 0), 0);
        txn("ws stall", 3, mk(13'h040, 0, 32'h0, WORD, 0, 32'hCAFEF00D, 0), 5);
        txn("ws next",  3, mk(13'h042, 0, 32'h0, HALF, 1, 32'hFFFFCAFE, 0), 0);

        // Reset during the store wait must not touch the target word.
        txn("rst pre", 3, mk(13'h050, 1, 32'h11111111, WORD, 0, 32'h0, 0), 0);
        req_addr = 13'h050; req_write = 1'b1; req_wdata = 32'h22222222;
        req_size = WORD; req_sign = 1'b0; valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid3 = 1'b0;
        @(negedge clk);
        chk("rst access ready", 32'(rdy3), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("rst rsp_valid", 32'(vld3), 32'd0);
        chk("rst req_ready", 32'(rdy3), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst release ready", 32'(rdy3), 32'd1);
        chk("rst release valid", 32'(vld3), 32'd0);
        txn("rst post", 3, mk(13'h050, 0, 32'h0, WORD, 0, 32'h11111111, 0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
